// File: rtl/ena_scheduler.sv
// ena_scheduler
//   Fires exactly one excited signal of a generated synchronous circuit model
//   per step by driving its one-hot `ena` vector. The start point of the
//   priority scan is either a 16-bit Galois LFSR (random interleavings) or a
//   round-robin pointer. The block also flags deadlock (nothing excited) and
//   counts firings.
//
//   Optional feature: define ENA_SCHED_MASK_EN to add a `mask` input. Masked
//   bits are removed from the candidate set (cand = excited & ~mask).
//
// Ports
//   clk          clock
//   reset        asynchronous, active-high reset
//   go           free-run: keep firing while high
//   step         single-step request, honoured only in IDLE with go low
//   mode         0 = LFSR start index, 1 = round-robin start index
//   excited[N]   bit i set = signal i would change if enabled
//   mask[N]      (ENA_SCHED_MASK_EN only) bits that may not fire
//   ena[N]       one-hot fire strobe, zero when not firing
//   fired_valid  pulses together with ena
//   fired_idx    index of the fired bit, valid with fired_valid
//   deadlock     high while stuck with no candidate
//   step_count   firings since reset, wraps at 2^CNT_W
module ena_scheduler #(
  parameter int          N     = 8,
  parameter int          IDX_W = 3,
  parameter int          CNT_W = 32,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             step,
  input  logic             mode,
  input  logic [N-1:0]     excited,
`ifdef ENA_SCHED_MASK_EN
  input  logic [N-1:0]     mask,
`endif
  output logic [N-1:0]     ena,
  output logic             fired_valid,
  output logic [IDX_W-1:0] fired_idx,
  output logic             deadlock,
  output logic [CNT_W-1:0] step_count
);

  typedef enum logic [2:0] {IDLE, PICK, FIRE, SETTLE, DEAD} state_t;

  localparam logic [15:0]    N16  = 16'(N);
  localparam logic [IDX_W:0] NW   = (IDX_W+1)'(N);
  localparam logic [15:0]    TAPS = 16'hB400;
  localparam logic [N-1:0]   ONE  = {{(N-1){1'b0}}, 1'b1};

  state_t           state;
  logic [15:0]      lfsr;
  logic [IDX_W-1:0] rr_ptr;
  logic [N-1:0]     cand;
  logic [IDX_W-1:0] start_idx;
  logic [IDX_W-1:0] pick_idx;

  // LFSR value reduced to a start index in [0, N)
  function automatic logic [IDX_W-1:0] lfsr_to_idx(input logic [15:0] v);
    return IDX_W'(v % N16);
  endfunction

  // First set bit of c scanning s, s+1, ... with wrap-around modulo N
  function automatic logic [IDX_W-1:0] scan_first(input logic [N-1:0]     c,
                                                  input logic [IDX_W-1:0] s);
    logic [IDX_W-1:0] r;
    logic             found;
    logic [IDX_W:0]   j;
    r     = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = {1'b0, s} + (IDX_W+1)'(k);
      if (j >= NW) j = j - NW;
      if (!found && c[j[IDX_W-1:0]]) begin
        r     = j[IDX_W-1:0];
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // (p + 1) mod N
  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] p);
    logic [IDX_W:0] t;
    t = {1'b0, p} + (IDX_W+1)'(1);
    if (t >= NW) t = '0;
    return t[IDX_W-1:0];
  endfunction

`ifdef ENA_SCHED_MASK_EN
  assign cand = excited & ~mask;
`else
  assign cand = excited;
`endif

  assign start_idx = mode ? rr_ptr : lfsr_to_idx(lfsr);
  assign pick_idx  = scan_first(cand, start_idx);

  // Outputs are registered on the edge that enters FIRE, so ena is high for
  // exactly the one cycle the FSM spends in FIRE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      lfsr        <= SEED;
      rr_ptr      <= '0;
      ena         <= '0;
      fired_valid <= 1'b0;
      fired_idx   <= '0;
      deadlock    <= 1'b0;
      step_count  <= '0;
    end else begin
      // Free-running Galois LFSR, independent of FSM state
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);

      case (state)
        IDLE: begin
          if (go || step) state <= PICK;
        end
        PICK: begin
          if (cand == '0) begin
            state    <= DEAD;
            deadlock <= 1'b1;
          end else begin
            state       <= FIRE;
            ena         <= ONE << pick_idx;
            fired_valid <= 1'b1;
            fired_idx   <= pick_idx;
            step_count  <= step_count + CNT_W'(1);
            rr_ptr      <= next_ptr(pick_idx);
          end
        end
        FIRE: begin
          ena         <= '0;
          fired_valid <= 1'b0;
          state       <= SETTLE;
        end
        SETTLE: begin
          // One quiet cycle lets the model's precap nets settle before excited
          // is sampled again.
          state <= go ? PICK : IDLE;
        end
        DEAD: begin
          if (!go && !step) begin
            state    <= IDLE;
            deadlock <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ena_scheduler.md
Name: ena_scheduler

Overview:
- Drives the per-signal `ena` vector of a generated synchronous circuit model; it sits on the opposite side of that vector from the model.
- Each model signal is a DFF that updates only when its `ena` bit is high. This block watches which signals are excited and fires exactly one of them per step.
- Selection is pseudo-random (LFSR) or round-robin, so a single clock can exercise asynchronous interleavings.
- It also detects deadlock (nothing excited) and counts fired transitions.

Parameters:
- N, 8, number of `ena` bits (model inputs plus gates); N >= 2.
- IDX_W, 3, index width; must be >= clog2(N).
- CNT_W, 32, width of the step counter.
- SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- go  input  1  free-run enable: fire continuously while high.
- step  input  1  single-step request; used only when go=0.
- mode  input  1  0 = LFSR random start, 1 = round-robin start.
- excited  input  N  bit i high = signal i would change if enabled (precap != Q, or input allowed to toggle).
- ena  output  N  one-hot fire strobe to the model; all-zero otherwise.
- fired_valid  output  1  pulses with `ena`.
- fired_idx  output  IDX_W  index of the bit fired; valid with fired_valid.
- deadlock  output  1  high while in DEAD.
- step_count  output  CNT_W  number of firings since reset.

Behaviour:
- Interface: one clock, `clk`. Reset `reset` is asynchronous and active-high. All outputs are registered.
- Reset values: ena=0, fired_valid=0, fired_idx=0, deadlock=0, step_count=0, lfsr=SEED, rr_ptr=0, state=IDLE.
- LFSR: 16-bit Galois, taps 16'hB400. It shifts every clock outside reset, regardless of state.
- Candidates: cand = excited.
- FSM states: IDLE, PICK, FIRE, SETTLE, DEAD.
- IDLE: go=1, or (go=0 and step=1), -> PICK. A step arriving while go=1 is ignored. A step in any state other than IDLE is dropped.
- PICK:
  - Start index s = lfsr % N when mode=0; s = rr_ptr when mode=1.
  - Select the first set bit of cand scanning s, s+1, ... with wrap-around modulo N. The scan is combinational and the result is registered into sel.
  - cand==0 -> DEAD; otherwise -> FIRE.
- FIRE (exactly one cycle):
  - ena = 1<<sel, fired_valid=1, fired_idx=sel.
  - step_count increments, wrapping at 2^CNT_W.
  - rr_ptr = (sel+1) % N, so rr_ptr=N-1 wraps to 0.
  - -> SETTLE.
- SETTLE (one cycle): ena=0, giving the model's combinational precap nets time to settle before excited is sampled again. Then -> PICK if go=1, else -> IDLE.
- Throughput: one firing every 3 cycles while go is held.
- DEAD: deadlock=1 and ena=0. Exit to IDLE only when go=0 and step=0 in the same cycle; deadlock clears on exit. Re-entering PICK with cand still zero returns to DEAD.
- excited changing during FIRE/SETTLE: ignored; only the value sampled in PICK matters.
- Reset asserted mid-FIRE: ena drops to 0 asynchronously, with no partial pulse counted.
- Invariant: ena is one-hot or zero in every cycle; popcount(ena) <= 1.

Optional Feature:
- Macro: ENA_SCHED_MASK_EN.
- Defined:
  - Adds port `mask  input  N`; cand = excited & ~mask. The testbench or environment uses it to forbid input toggles disallowed by the spec.
  - When excited != 0 but cand == 0, the block goes to DEAD.
- Undefined: no mask port, and cand = excited.

Test Plan:
- Reset then idle: reset high 2 cycles, go=0, step=0 -> ena=0, step_count=0, deadlock=0 for 20 cycles.
- Round-robin: N=8, mode=1, excited=8'b1000_0101, go=1 -> fired_idx sequence 0, 2, 7, 0, 2; step_count=5 after 15 cycles; ena one-hot on FIRE cycles only.
- Single-step: go=0, excited=8'hFF, 3 step pulses spaced 5 cycles apart -> exactly 3 fired_valid pulses; step_count=3; a step issued during SETTLE is dropped.
- Deadlock: excited=0, go=1 -> deadlock=1 by the 2nd cycle after go, ena stays 0. Drop go -> deadlock=0 and state IDLE.
- Random fairness: mode=0, excited=8'hFF, 3000 cycles -> 1000 firings; every index fires at least 60 times; the sequence repeats identically after reset with the same SEED.
- Mask (ENA_SCHED_MASK_EN): excited=8'h0F, mask=8'h0E -> only idx 0 fires. Then mask=8'h0F -> DEAD.
- Async reset mid-FIRE: ena clears in the same cycle and step_count=0.
